mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer that shares the single-port data memory between the processor's load/store path (port 0) and a program loader / debug port (port 1). It sits between the requesters and the data memory. It latches one request at a time, drives the memory for exactly one access cycle and waits out the memory read latency. It then returns data with a one-cycle acknowledge, using round-robin priority when both ports request together.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the two-port data memory arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_id
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter: latches one request, issues a single memory
// access, waits MEM_LAT cycles for read data and returns a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pick;

  // last resets to 1 so port 0 wins the first tie after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    pick     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          grant_d = pick;
          last_d  = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      // Data is valid in the last WAIT cycle, when the counter reads 1
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (grant_q) begin
            rdata1_d = bus.mem_rdata;
          end else begin
            rdata0_d = bus.mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ack0      = (state_q == DONE) && !grant_q;
  assign bus.ack1      = (state_q == DONE) && grant_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single transactions plus
// hand-written arbitration, abort and re-arbitration sequences, with a scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: reads return data MEM_LAT cycles after the mem_en cycle,
  // and a poison word in every other slot so a mistimed capture shows up
  logic [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] pipe [0:MEM_LAT-1];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hBAADF00D;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  typedef struct packed {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef struct packed {
    logic              port;
    logic              rd;
    logic [DATA_W-1:0] rdata;
  } ack_t;

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_lat;
  } vec_t;

  acc_t expAcc[$];
  ack_t expAck[$];
  acc_t accHead;
  ack_t ackHead;
  int   memEnCount = 0;
  int   ack0Count = 0;
  logic [DATA_W-1:0] expR0 = '0;
  logic [DATA_W-1:0] expR1 = '0;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every memory access and every ack is matched against the
  // oldest expectation queued when the stimulus was driven
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_en) begin
        memEnCount++;
        checkOutput("sb_access_expected", 32'(expAcc.size() != 0), 32'd1);
        if (expAcc.size() != 0) begin
          accHead = expAcc.pop_front();
          checkOutput("sb_grant_id", 32'(bus.grant_id), 32'(accHead.port));
          checkOutput("sb_mem_we", 32'(bus.mem_we), 32'(accHead.we));
          checkOutput("sb_mem_addr", 32'(bus.mem_addr), 32'(accHead.addr));
          if (accHead.we) checkOutput("sb_mem_wdata", bus.mem_wdata, accHead.wdata);
        end
      end
      if (bus.ack0) ack0Count++;
      if (bus.ack0 || bus.ack1) begin
        checkOutput("sb_ack_onehot", 32'(bus.ack0 && bus.ack1), 32'd0);
        checkOutput("sb_ack_expected", 32'(expAck.size() != 0), 32'd1);
        if (expAck.size() != 0) begin
          ackHead = expAck.pop_front();
          checkOutput("sb_ack_port", 32'(bus.ack1), 32'(ackHead.port));
          if (ackHead.rd)
            checkOutput("sb_rdata", ackHead.port ? bus.rdata1 : bus.rdata0, ackHead.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic expectTxn(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata);
    expAcc.push_back('{port: port, we: we, addr: addr, wdata: wdata});
    expAck.push_back('{port: port, rd: !we, rdata: rdata});
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    expAcc.delete();
    expAck.delete();
    expR0 = '0;
    expR1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitAck(input logic port, input string name,
                         output int cyc, output int busyCyc, output int memEnCyc);
    cyc = 0; busyCyc = 0; memEnCyc = 0;
    while (1) begin
      tick();
      cyc++;
      if (bus.busy) busyCyc++;
      if (bus.mem_en && memEnCyc == 0) memEnCyc = cyc;
      if (port ? bus.ack1 : bus.ack0) break;
      if (cyc >= 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: no ack%0d within %0d cycles, expected one", name, port, cyc);
        break;
      end
    end
  endtask

  task automatic runVector(input vec_t v);
    int cyc, busyCyc, memEnCyc;
    applyStimulus(v.port, 1'b1, v.we, v.addr, v.wdata);
    expectTxn(v.port, v.we, v.addr, v.wdata, v.exp_rdata);
    waitAck(v.port, "vec_ack", cyc, busyCyc, memEnCyc);
    applyStimulus(v.port, 1'b0, v.we, v.addr, v.wdata);
    if (!v.we) begin
      if (v.port) expR1 = v.exp_rdata;
      else        expR0 = v.exp_rdata;
    end
    checkOutput("vec_mem_en_cycle", 32'(memEnCyc), 32'd1);
    checkOutput("vec_ack_latency", 32'(cyc), 32'(v.exp_lat));
    checkOutput("vec_busy_cycles", 32'(busyCyc), 32'(v.exp_lat));
    checkOutput("vec_rdata0", bus.rdata0, expR0);
    checkOutput("vec_rdata1", bus.rdata1, expR1);
    tick();
    checkOutput("vec_busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc, busyCyc, memEnCyc, base, acks, a0;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC0DE0000 | 32'(i);
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    vecs[0] = '{port: 1'b0, we: 1'b1, addr: 10'h005, wdata: 32'hDEADBEEF, exp_rdata: 32'h0,        exp_lat: 2};
    vecs[1] = '{port: 1'b1, we: 1'b0, addr: 10'h005, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF, exp_lat: 5};
    vecs[2] = '{port: 1'b0, we: 1'b0, addr: 10'h123, wdata: 32'h0,        exp_rdata: 32'hC0DE0123, exp_lat: 5};
    vecs[3] = '{port: 1'b1, we: 1'b1, addr: 10'h3FF, wdata: 32'h12345678, exp_rdata: 32'h0,        exp_lat: 2};
    vecs[4] = '{port: 1'b0, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        exp_rdata: 32'h12345678, exp_lat: 5};
    vecs[5] = '{port: 1'b1, we: 1'b0, addr: 10'h000, wdata: 32'h0,        exp_rdata: 32'hC0DE0000, exp_lat: 5};
    vecs[6] = '{port: 1'b0, we: 1'b1, addr: 10'h000, wdata: 32'hFFFFFFFF, exp_rdata: 32'h0,        exp_lat: 2};
    vecs[7] = '{port: 1'b1, we: 1'b0, addr: 10'h000, wdata: 32'h0,        exp_rdata: 32'hFFFFFFFF, exp_lat: 5};

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst_ack0", 32'(bus.ack0), 32'd0);
    checkOutput("rst_ack1", 32'(bus.ack1), 32'd0);
    checkOutput("rst_rdata0", bus.rdata0, 32'd0);
    checkOutput("rst_rdata1", bus.rdata1, 32'd0);
    checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] single-transaction vectors");
    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    $display("[TB] address change after grant is ignored");
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h010, 32'hA0A0A0A0);
    expectTxn(1'b0, 1'b1, 10'h010, 32'hA0A0A0A0, 32'h0);
    @(posedge clk);
    #1 bus.addr0 = 10'h3FF;
    waitAck(1'b0, "addr_change_ack", cyc, busyCyc, memEnCyc);
    bus.req0 = 1'b0;
    tick();
    checkOutput("addr_change_mem", mem[10'h010], 32'hA0A0A0A0);
    checkOutput("addr_change_untouched", mem[10'h3FF], 32'h12345678);

    $display("[TB] continuous requests from both ports alternate");
    resetDut();
    base = memEnCount;
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h020, 32'h11111111);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h020, 32'h0);
    expectTxn(1'b0, 1'b1, 10'h020, 32'h11111111, 32'h0);
    expectTxn(1'b1, 1'b0, 10'h020, 32'h0, 32'h11111111);
    expectTxn(1'b0, 1'b1, 10'h020, 32'h11111111, 32'h0);
    expectTxn(1'b1, 1'b0, 10'h020, 32'h0, 32'h11111111);
    acks = 0;
    cyc = 0;
    while (acks < 4 && cyc < 80) begin
      tick();
      cyc++;
      acks += int'(bus.ack0) + int'(bus.ack1);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    expR1 = 32'h11111111;
    checkOutput("alt_acks", 32'(acks), 32'd4);
    checkOutput("alt_cycles", 32'(cyc), 32'(2 * 3 + 2 * (MEM_LAT + 3) - 1));
    tick();
    checkOutput("alt_mem_en_count", 32'(memEnCount - base), 32'd4);
    checkOutput("alt_queue_empty", 32'(expAcc.size() + expAck.size()), 32'd0);
    checkOutput("alt_rdata0", bus.rdata0, expR0);

    $display("[TB] held request and re-arbitration against last grant");
    base = memEnCount;
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    expectTxn(1'b0, 1'b0, 10'h3FF, 32'h0, 32'h12345678);
    expectTxn(1'b1, 1'b1, 10'h055, 32'h55555555, 32'h0);
    expectTxn(1'b0, 1'b0, 10'h3FF, 32'h0, 32'h12345678);
    waitAck(1'b0, "hold_first_ack", cyc, busyCyc, memEnCyc);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h055, 32'h55555555);
    waitAck(1'b1, "rearb_ack1", cyc, busyCyc, memEnCyc);
    bus.req1 = 1'b0;
    checkOutput("rearb_mem_en_cycle", 32'(memEnCyc), 32'd2);
    checkOutput("rearb_ack_cycle", 32'(cyc), 32'd3);
    waitAck(1'b0, "hold_second_ack", cyc, busyCyc, memEnCyc);
    bus.req0 = 1'b0;
    expR0 = 32'h12345678;
    checkOutput("hold_second_latency", 32'(cyc), 32'(MEM_LAT + 3));
    checkOutput("hold_rdata0", bus.rdata0, expR0);
    checkOutput("hold_rdata1", bus.rdata1, expR1);
    tick();
    checkOutput("hold_mem_en_count", 32'(memEnCount - base), 32'd3);
    checkOutput("hold_mem_write", mem[10'h055], 32'h55555555);

    $display("[TB] request dropped before grant");
    base = memEnCount;
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h077, 32'h77777777);
    expectTxn(1'b0, 1'b1, 10'h077, 32'h77777777, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h066, 32'h66666666);
    waitAck(1'b0, "drop_ack0", cyc, busyCyc, memEnCyc);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) tick();
    checkOutput("drop_mem_en_count", 32'(memEnCount - base), 32'd1);
    checkOutput("drop_no_write", mem[10'h066], 32'hC0DE0066);
    checkOutput("drop_busy", 32'(bus.busy), 32'd0);

    $display("[TB] reset during read wait");
    resetDut();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h005, 32'h0);
    expectTxn(1'b0, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF);
    tick();
    tick();
    checkOutput("abort_in_wait", 32'(bus.busy && !bus.mem_en), 32'd1);
    a0 = ack0Count;
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_ack0", 32'(bus.ack0), 32'd0);
    bus.req0 = 1'b0;
    expAck.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("abort_no_ack", 32'(ack0Count - a0), 32'd0);
    checkOutput("abort_rdata0", bus.rdata0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h0AA, 32'hAAAAAAAA);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h0BB, 32'hBBBBBBBB);
    expectTxn(1'b0, 1'b1, 10'h0AA, 32'hAAAAAAAA, 32'h0);
    expectTxn(1'b1, 1'b1, 10'h0BB, 32'hBBBBBBBB, 32'h0);
    waitAck(1'b0, "tie_ack0", cyc, busyCyc, memEnCyc);
    bus.req0 = 1'b0;
    checkOutput("tie_first_latency", 32'(cyc), 32'd2);
    waitAck(1'b1, "tie_ack1", cyc, busyCyc, memEnCyc);
    bus.req1 = 1'b0;
    checkOutput("tie_second_latency", 32'(cyc), 32'd3);
    tick();
    checkOutput("tie_queue_empty", 32'(expAcc.size() + expAck.size()), 32'd0);
    checkOutput("tie_mem_bb", mem[10'h0BB], 32'hBBBBBBBB);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
